// File: rtl/mix_columns_seq.sv
// mix_columns_seq: sequential AES MixColumns/InvMixColumns engine with valid/ready on both sides,
// transforming COLS_PER_CYCLE columns of an NB-column state per clock.
module mix_columns_seq #(
    parameter int WORD_SIZE      = 8,
    parameter int NB             = 4,
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      inverse,
    input  logic [WORD_SIZE*4*NB-1:0] state,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WORD_SIZE*4*NB-1:0] state_out
);
    localparam int W  = WORD_SIZE * 4 * NB;
    localparam int CW = $clog2(NB + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

    fsm_t          fsm_q, fsm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  work_q, work_d, out_q, out_d, mixed;
    logic          inv_q, inv_d, live_q, accept, last;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Each set bit of the coefficient selects one term of the xtime chain a, 2a, 4a, 8a.
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] x2, x4, x8;
        x2 = xt(a);
        x4 = xt(x2);
        x8 = xt(x4);
        return (c[3] ? x8 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[0] ? a : 8'h00);
    endfunction

    function automatic logic [31:0] mix(input logic [31:0] col, input logic inv);
        logic [15:0] cf;
        logic [7:0]  b;
        logic [31:0] res;
        cf  = inv ? 16'hebd9 : 16'h2311;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            b = 8'h00;
            for (int k = 0; k < 4; k++)
                b ^= gm(col[(3 - (r + k) % 4) * 8 +: 8], cf[(3 - k) * 4 +: 4]);
            res[(3 - r) * 8 +: 8] = b;
        end
        return res;
    endfunction

    always_comb begin
        mixed = work_q;
        for (int j = 0; j < COLS_PER_CYCLE; j++)
            mixed[(NB - 1 - int'(cnt_q) - j) * 32 +: 32] = mix(work_q[(NB - 1 - int'(cnt_q) - j) * 32 +: 32], inv_q);
    end

    always_comb begin
        fsm_d     = fsm_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        inv_d     = inv_q;
        out_d     = out_q;
        out_valid = fsm_q == DONE;
        in_ready  = live_q & (fsm_q == IDLE || (fsm_q == DONE && out_ready));
        accept    = in_valid & in_ready;
        last      = cnt_q == CW'(NB - COLS_PER_CYCLE);
        if (fsm_q == BUSY) begin
            work_d = mixed;
            cnt_d  = cnt_q + CW'(COLS_PER_CYCLE);
            fsm_d  = last ? DONE : BUSY;
            out_d  = last ? mixed : out_q;
        end
        if (fsm_q == DONE && out_ready) fsm_d = IDLE;
        if (accept) begin
            fsm_d  = BUSY;
            cnt_d  = '0;
            work_d = state;
            inv_d  = inverse;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q  <= IDLE;
            cnt_q  <= '0;
            work_q <= '0;
            out_q  <= '0;
            inv_q  <= 1'b0;
            live_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            work_q <= work_d;
            out_q  <= out_d;
            inv_q  <= inv_d;
            live_q <= 1'b1;
        end
    end

    assign state_out = out_q;
endmodule

// File: tb/tb_mix_columns_seq.sv
// tb_mix_columns_seq: directed FIPS-197 and edge-case vectors for mix_columns_seq across
// NB=4 (CPC 1/2/4) and NB=8 (CPC 2).
module tb_mix_columns_seq;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid = 0, inverse = 0, out_ready = 0;
    logic [127:0] state_i = '0, so_a, so_b, so_c;
    logic         rdy_a, rdy_b, rdy_c, ov_a, ov_b, ov_c;

    logic         in_valid_d = 0, inverse_d = 0, out_ready_d = 0;
    logic [255:0] state_d = '0, so_d;
    logic         rdy_d, ov_d;

    int nvec = 0, nerr = 0, la, lb, lc;

    mix_columns_seq #(.WORD_SIZE(8), .NB(4), .COLS_PER_CYCLE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a), .inverse(inverse),
        .state(state_i), .out_valid(ov_a), .out_ready(out_ready), .state_out(so_a));
    mix_columns_seq #(.WORD_SIZE(8), .NB(4), .COLS_PER_CYCLE(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b), .inverse(inverse),
        .state(state_i), .out_valid(ov_b), .out_ready(out_ready), .state_out(so_b));
    mix_columns_seq #(.WORD_SIZE(8), .NB(4), .COLS_PER_CYCLE(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_c), .inverse(inverse),
        .state(state_i), .out_valid(ov_c), .out_ready(out_ready), .state_out(so_c));
    mix_columns_seq #(.WORD_SIZE(8), .NB(8), .COLS_PER_CYCLE(2)) dut_d (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_d), .in_ready(rdy_d), .inverse(inverse_d),
        .state(state_d), .out_valid(ov_d), .out_ready(out_ready_d), .state_out(so_d));

    localparam logic [127:0] T1_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] T1_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] ALL01  = {16{8'h01}};

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_a();
        la = 0; lb = 0; lc = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (ov_b && lb == 0) lb = i;
            if (ov_c && lc == 0) lc = i;
            if (ov_a) begin la = i; break; end
        end
    endtask

    task automatic xfer(input logic [127:0] d, input logic inv, input logic [127:0] exp, input string tag);
        in_valid = 1; state_i = d; inverse = inv;
        #1 check({tag, " in_ready"}, 256'(rdy_a), 256'(1));
        @(posedge clk); #1;
        in_valid = 0; inverse = ~inv;
        wait_a();
        check({tag, " latency"}, 256'(la), 256'(4));
        check({tag, " data"}, 256'(so_a), 256'(exp));
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        check({tag, " drained"}, 256'(ov_a), 256'(0));
    endtask

    task automatic xfer_d(input logic [255:0] d, input logic inv, input logic [255:0] exp, input string tag);
        int n;
        in_valid_d = 1; state_d = d; inverse_d = inv;
        @(posedge clk); #1;
        in_valid_d = 0; inverse_d = ~inv;
        n = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (ov_d) begin n = i; break; end
        end
        check({tag, " latency"}, 256'(n), 256'(4));
        check({tag, " data"}, so_d, exp);
        out_ready_d = 1;
        @(posedge clk); #1;
        out_ready_d = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", 256'(ov_a), 256'(0));
        check("rst state_out", 256'(so_a), 256'(0));
        check("rst in_ready", 256'(rdy_a), 256'(0));
        rst_n = 1;
        @(posedge clk); #1;
        check("post-rst in_ready", 256'(rdy_a), 256'(1));

        xfer(T1_IN, 1'b0, T1_OUT, "fips_fwd");
        check("cpc2 latency", 256'(lb), 256'(2));
        check("cpc4 latency", 256'(lc), 256'(1));
        check("cpc2 data", 256'(so_b), 256'(T1_OUT));
        check("cpc4 data", 256'(so_c), 256'(T1_OUT));

        xfer(T1_OUT, 1'b1, T1_IN, "fips_inv");
        xfer({32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6}, 1'b1,
             {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6}, "cols_inv");
        xfer({32'hd4d4d4d5, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6}, 1'b0,
             {32'hd5d5d7d6, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6}, "cols_fwd");

        // Backpressure, then back-to-back acceptance in the same edge as the drain
        in_valid = 1; state_i = T1_IN; inverse = 0;
        @(posedge clk); #1;
        in_valid = 0;
        wait_a();
        check("bp latency", 256'(la), 256'(4));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp out_valid", 256'(ov_a), 256'(1));
            check("bp state_out", 256'(so_a), 256'(T1_OUT));
            check("bp in_ready", 256'(rdy_a), 256'(0));
        end
        in_valid = 1; state_i = ALL01; inverse = 1; out_ready = 1;
        #1 check("b2b in_ready", 256'(rdy_a), 256'(1));
        @(posedge clk); #1;
        in_valid = 0; out_ready = 0;
        check("b2b out_valid", 256'(ov_a), 256'(0));
        check("b2b busy", 256'(rdy_a), 256'(0));
        wait_a();
        check("b2b latency", 256'(la), 256'(4));
        check("b2b data", 256'(so_a), 256'(ALL01));
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;

        xfer_d({8{32'hdb135345}}, 1'b0, {8{32'h8e4da1bc}}, "nb8_fwd");
        xfer_d({8{32'h8e4da1bc}}, 1'b1, {8{32'hdb135345}}, "nb8_inv");

        // Reset two clocks into BUSY discards the in-flight state
        in_valid = 1; state_i = T1_OUT; inverse = 1;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        check("midrst out_valid", 256'(ov_a), 256'(0));
        check("midrst state_out", 256'(so_a), 256'(0));
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        check("rel in_ready", 256'(rdy_a), 256'(1));
        check("rel out_valid", 256'(ov_a), 256'(0));
        xfer(T1_IN, 1'b0, T1_OUT, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
